// File: rtl/wave_pkg.sv
// Shared types, widths and helpers for the waveform display blocks.
package wave_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [23:0] COLOR_CH0 = 24'hFFFF00;
  localparam logic [23:0] COLOR_CH1 = 24'h00FFFF;
  localparam logic [23:0] COLOR_CH2 = 24'h00FF00;
  localparam logic [23:0] COLOR_CH3 = 24'hFF00FF;

  // Channel 0 occupies the least-significant 24 bits.
  localparam logic [95:0] DEFAULT_CH_COLORS = {COLOR_CH3, COLOR_CH2, COLOR_CH1, COLOR_CH0};

  // True when y lies within the closed span of a and b, in either order.
  function automatic logic abs_between(input logic [Y_W-1:0] y,
                                       input logic [Y_W-1:0] a,
                                       input logic [Y_W-1:0] b);
    logic [Y_W-1:0] lo;
    logic [Y_W-1:0] hi;
    if (a <= b) begin
      lo = a;
      hi = b;
    end else begin
      lo = b;
      hi = a;
    end
    return (y >= lo) && (y <= hi);
  endfunction

endpackage

// File: rtl/wave_channel.sv
// One trace: maps a RAM sample to a screen row and tests the current row for a hit.
module wave_channel
  import wave_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int Y_START  = 32,
  parameter int Y_SHIFT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] read_value,
  input  logic                first_col,
  input  logic                idx_chg,
  input  logic [Y_W-1:0]      y,
  input  logic                line_mode,
  output logic                hit
);

  logic [Y_W-1:0] plot_y_s;
  logic [Y_W-1:0] prev_eff_s;
  logic [Y_W-1:0] prev_y_r;

  assign plot_y_s = Y_W'(Y_START) + Y_W'(read_value >> Y_SHIFT);

  // The first column of the window starts a fresh trace, so no line joins it to stale data.
  assign prev_eff_s = first_col ? plot_y_s : prev_y_r;

  // Remember the row of the last sample once the sample index moves on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_y_r <= Y_W'(Y_START);
    end else if (first_col || idx_chg) begin
      prev_y_r <= plot_y_s;
    end
  end

  // Dot mode hits one row; line mode fills the span back to the previous sample.
  always_comb begin
    hit = 1'b0;
    if (line_mode) begin
      hit = abs_between(y, prev_eff_s, plot_y_s);
    end else begin
      hit = (y == plot_y_s);
    end
  end

endmodule

// File: rtl/wave_display_multi.sv
// Multi-channel waveform overlay: frame latch, RAM addressing, stage-1 pipe and priority colouring.
module wave_display_multi
  import wave_pkg::*;
#(
  parameter int          NCH          = 2,
  parameter int          SAMPLE_W     = 8,
  parameter int          SAMPLES_LOG2 = 8,
  parameter int          X_START      = 256,
  parameter int          Y_START      = 32,
  parameter int          Y_SHIFT      = 1,
  parameter logic [95:0] CH_COLORS    = DEFAULT_CH_COLORS,
  localparam int         ADDR_W       = SAMPLES_LOG2 + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [X_W-1:0]          x,
  input  logic [Y_W-1:0]          y,
  input  logic                    valid,
  input  logic                    read_index,
  input  logic                    line_mode,
  input  logic [NCH-1:0]          ch_enable,
  output logic [NCH*ADDR_W-1:0]   read_address,
  input  logic [NCH*SAMPLE_W-1:0] read_value,
  output logic                    valid_pixel,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b
);

  localparam int X_END = X_START + (1 << (SAMPLES_LOG2 + 1));

  logic                    buf_sel_r;
  logic                    mode_q_r;
  logic [NCH-1:0]          en_q_r;
  logic                    x_in_range_s;
  logic                    first_col_s;
  logic [X_W-1:0]          x_off_s;
  logic [SAMPLES_LOG2-1:0] sample_idx_s;
  logic                    s1_in_win_r;
  logic [Y_W-1:0]          s1_y_r;
  logic                    s1_first_col_r;
  logic [SAMPLES_LOG2-1:0] s1_idx_r;
  logic                    s1_chg_r;
  logic [NCH-1:0]          hit_s;
  logic [NCH-1:0]          qual_s;
  logic                    any_s;
  rgb_t                    color_s;

  assign x_in_range_s = ({1'b0, x} >= 12'(X_START)) && ({1'b0, x} < 12'(X_END));
  assign first_col_s  = (x == X_W'(X_START));
  assign x_off_s      = x - X_W'(X_START);

  // Index is forced to zero outside the window and while reset holds the block.
  always_comb begin
    sample_idx_s = '0;
    if (reset && x_in_range_s) begin
      sample_idx_s = SAMPLES_LOG2'(x_off_s >> 1);
    end else begin
      sample_idx_s = '0;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_addr
    assign read_address[ch*ADDR_W +: ADDR_W] = {buf_sel_r, sample_idx_s};
  end

  // Frame-start latch: buffer, draw mode and enables are fixed for a whole frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_sel_r <= 1'b0;
      mode_q_r  <= 1'b0;
      en_q_r    <= '1;
    end else if (valid && (x == '0) && (y == '0)) begin
      buf_sel_r <= read_index;
      mode_q_r  <= line_mode;
      en_q_r    <= ch_enable;
    end
  end

  // Stage 1 lines up with the RAM data returned for this pixel's address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_in_win_r    <= 1'b0;
      s1_y_r         <= '0;
      s1_first_col_r <= 1'b0;
      s1_idx_r       <= '0;
      s1_chg_r       <= 1'b0;
    end else begin
      s1_in_win_r    <= valid && x_in_range_s;
      s1_y_r         <= y;
      s1_first_col_r <= first_col_s;
      s1_idx_r       <= sample_idx_s;
      s1_chg_r       <= (sample_idx_s != s1_idx_r);
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    wave_channel #(
      .SAMPLE_W (SAMPLE_W),
      .Y_START  (Y_START),
      .Y_SHIFT  (Y_SHIFT)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .read_value (read_value[ch*SAMPLE_W +: SAMPLE_W]),
      .first_col  (s1_first_col_r),
      .idx_chg    (s1_chg_r),
      .y          (s1_y_r),
      .line_mode  (mode_q_r),
      .hit        (hit_s[ch])
    );
  end

  assign qual_s = hit_s & en_q_r & {NCH{s1_in_win_r}};

  // Walk from the highest channel down so the lowest-numbered hit wins.
  always_comb begin
    any_s   = |qual_s;
    color_s = '0;
    for (int ch = NCH - 1; ch >= 0; ch--) begin
      color_s = qual_s[ch] ? rgb_t'(CH_COLORS[ch*24 +: 24]) : color_s;
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_pixel <= 1'b0;
      r           <= 8'd0;
      g           <= 8'd0;
      b           <= 8'd0;
    end else begin
      valid_pixel <= any_s;
      r           <= color_s.r;
      g           <= color_s.g;
      b           <= color_s.b;
    end
  end

endmodule

// File: tb/tb_wave_display_multi.sv
// Scoreboard bench for wave_display_multi at default parameters with a 1-cycle RAM model.
module tb_wave_display_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic        line_mode;
  logic [1:0]  ch_enable;
  logic [17:0] read_address;
  logic [15:0] read_value;
  logic        valid_pixel;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  always #5 clk = ~clk;

  wave_display_multi dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .valid        (valid),
    .read_index   (read_index),
    .line_mode    (line_mode),
    .ch_enable    (ch_enable),
    .read_address (read_address),
    .read_value   (read_value),
    .valid_pixel  (valid_pixel),
    .r            (r),
    .g            (g),
    .b            (b)
  );

  logic [7:0] mem [2][512];

  always @(posedge clk) begin
    read_value[7:0]  <= mem[0][read_address[8:0]];
    read_value[15:8] <= mem[1][read_address[17:9]];
  end

  typedef struct {
    logic        vp;
    logic [23:0] rgb;
    logic [10:0] px;
    logic [9:0]  py;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic       m_buf;
  logic       m_mode;
  logic [1:0] m_en;
  logic [9:0] m_prev [2];
  logic [7:0] m_last_idx;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_buf      = 1'b0;
    m_mode     = 1'b0;
    m_en       = 2'b11;
    m_prev[0]  = 10'd32;
    m_prev[1]  = 10'd32;
    m_last_idx = 8'd0;
  endtask

  task automatic model_pix(input logic [10:0] px, input logic [9:0] py, input logic pv, output exp_t e);
    logic       in_rng;
    logic [7:0] idx;
    logic [9:0] plot [2];
    logic [9:0] eff;
    logic [9:0] lo;
    logic [9:0] hi;
    logic       hit;
    logic       chg;
    logic       first;
    in_rng = (px >= 11'd256) && (px < 11'd768);
    idx    = in_rng ? 8'((px - 11'd256) >> 1) : 8'd0;
    for (int ch = 0; ch < 2; ch++) plot[ch] = 10'd32 + 10'(mem[ch][{m_buf, idx}] >> 1);
    chg   = (idx != m_last_idx);
    first = (px == 11'd256);
    if (pv && px == 11'd0 && py == 10'd0) begin
      m_buf  = read_index;
      m_mode = line_mode;
      m_en   = ch_enable;
    end
    e.vp  = 1'b0;
    e.rgb = 24'd0;
    e.px  = px;
    e.py  = py;
    for (int ch = 1; ch >= 0; ch--) begin
      eff = first ? plot[ch] : m_prev[ch];
      lo  = (eff < plot[ch]) ? eff : plot[ch];
      hi  = (eff < plot[ch]) ? plot[ch] : eff;
      hit = m_mode ? (py >= lo && py <= hi) : (py == plot[ch]);
      if (hit && m_en[ch] && pv && in_rng) begin
        e.vp  = 1'b1;
        e.rgb = (ch == 0) ? 24'hFFFF00 : 24'h00FFFF;
      end
      if (first || chg) m_prev[ch] = plot[ch];
    end
    m_last_idx = idx;
  endtask

  // Compare the pixel driven two cycles ago, then drive and queue the next one.
  task automatic drive_pix(input logic [10:0] px, input logic [9:0] py, input logic pv,
                           input logic use_k = 1'b0, input logic kvp = 1'b0,
                           input logic [23:0] krgb = 24'd0);
    exp_t e;
    exp_t f;
    @(negedge clk);
    if (sbq.size() >= 2) begin
      f = sbq.pop_front();
      check_val($sformatf("vp@%0d,%0d", f.px, f.py), {31'd0, valid_pixel}, {31'd0, f.vp});
      check_val($sformatf("rgb@%0d,%0d", f.px, f.py), {8'd0, r, g, b}, {8'd0, f.rgb});
    end
    x     = px;
    y     = py;
    valid = pv;
    model_pix(px, py, pv, e);
    if (use_k) begin
      e.vp  = kvp;
      e.rgb = krgb;
    end
    sbq.push_back(e);
  endtask

  task automatic scan_row(input logic [9:0] py, input int x0, input int x1);
    for (int i = x0; i <= x1; i++) drive_pix(11'(i), py, 1'b1);
  endtask

  task automatic frame_start(input logic rid, input logic lm, input logic [1:0] en);
    read_index = rid;
    line_mode  = lm;
    ch_enable  = en;
    drive_pix(11'd0, 10'd0, 1'b1);
  endtask

  task automatic idle2();
    drive_pix(11'd0, 10'd1, 1'b0);
    drive_pix(11'd0, 10'd1, 1'b0);
  endtask

  initial begin
    reset      = 1'b0;
    x          = 11'd300;
    y          = 10'd0;
    valid      = 1'b0;
    read_index = 1'b0;
    line_mode  = 1'b0;
    ch_enable  = 2'b00;
    for (int i = 0; i < 512; i++) begin
      mem[0][i] = 8'(i);
      mem[1][i] = 8'd0;
    end
    model_reset();

    // Reset state, address gated to zero while held.
    #1;
    check_val("rst_vp", {31'd0, valid_pixel}, 32'd0);
    check_val("rst_rgb", {8'd0, r, g, b}, 32'd0);
    check_val("rst_addr", {14'd0, read_address}, 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // Before any frame start all channels are enabled in dot mode.
    drive_pix(11'd256, 10'd32, 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    drive_pix(11'd300, 10'd32, 1'b1, 1'b1, 1'b1, 24'h00FFFF);
    idle2();

    // Dot mode ramp on ch0, flat ch1.
    frame_start(1'b0, 1'b0, 2'b11);
    scan_row(10'd31, 250, 770);
    scan_row(10'd32, 250, 770);
    scan_row(10'd33, 250, 770);
    scan_row(10'd52, 250, 770);
    scan_row(10'd159, 250, 770);
    for (int k = 0; k < 256; k += 17)
      drive_pix(11'(256 + 2 * k), 10'(32 + k / 2), 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    drive_pix(11'd257, 10'd32, 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    drive_pix(11'd400, 10'd32, 1'b1, 1'b1, 1'b1, 24'h00FFFF);
    idle2();

    // Line mode step 0,200,0,...
    for (int i = 0; i < 512; i++) mem[0][i] = i[0] ? 8'd200 : 8'd0;
    frame_start(1'b0, 1'b1, 2'b01);
    scan_row(10'd32, 254, 262);
    scan_row(10'd80, 254, 262);
    scan_row(10'd133, 254, 262);
    for (int yy = 30; yy <= 134; yy++) begin
      drive_pix(11'd256, 10'(yy), 1'b1, 1'b1, yy == 32, (yy == 32) ? 24'hFFFF00 : 24'd0);
      drive_pix(11'd258, 10'(yy), 1'b1, 1'b1, (yy >= 32 && yy <= 132),
                (yy >= 32 && yy <= 132) ? 24'hFFFF00 : 24'd0);
    end
    idle2();

    // Enables.
    for (int i = 0; i < 512; i++) mem[0][i] = 8'(i);
    frame_start(1'b0, 1'b0, 2'b10);
    scan_row(10'd32, 250, 770);
    scan_row(10'd52, 250, 770);
    drive_pix(11'd256, 10'd32, 1'b1, 1'b1, 1'b1, 24'h00FFFF);
    drive_pix(11'd336, 10'd52, 1'b1, 1'b1, 1'b0, 24'd0);
    idle2();
    frame_start(1'b0, 1'b0, 2'b00);
    scan_row(10'd32, 250, 770);
    drive_pix(11'd256, 10'd32, 1'b1, 1'b1, 1'b0, 24'd0);
    idle2();

    // Window edges and exact latency.
    mem[0][0]   = 8'd20;
    mem[0][255] = 8'd20;
    frame_start(1'b0, 1'b0, 2'b01);
    drive_pix(11'd0, 10'd42, 1'b0, 1'b1, 1'b0, 24'd0);
    drive_pix(11'd255, 10'd42, 1'b1, 1'b1, 1'b0, 24'd0);
    drive_pix(11'd256, 10'd42, 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    drive_pix(11'd0, 10'd42, 1'b0, 1'b1, 1'b0, 24'd0);
    drive_pix(11'd767, 10'd42, 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    drive_pix(11'd768, 10'd42, 1'b1, 1'b1, 1'b0, 24'd0);
    drive_pix(11'd0, 10'd42, 1'b0, 1'b1, 1'b0, 24'd0);
    idle2();
    mem[0][0]   = 8'd0;
    mem[0][255] = 8'd255;

    // Buffer select only moves at frame start.
    frame_start(1'b0, 1'b0, 2'b11);
    scan_row(10'd300, 296, 299);
    read_index = 1'b1;
    drive_pix(11'd300, 10'd300, 1'b1);
    #1;
    check_val("buf_mid0", {31'd0, read_address[8]}, 32'd0);
    check_val("buf_mid1", {31'd0, read_address[17]}, 32'd0);
    scan_row(10'd301, 296, 300);
    #1;
    check_val("buf_mid_late", {31'd0, read_address[8]}, 32'd0);
    drive_pix(11'd0, 10'd0, 1'b1);
    drive_pix(11'd300, 10'd0, 1'b1);
    #1;
    check_val("buf_new0", {23'd0, read_address[8:0]}, 32'h116);
    check_val("buf_new1", {23'd0, read_address[17:9]}, 32'h116);
    idle2();

    // Asynchronous reset mid-line.
    drive_pix(11'd255, 10'd32, 1'b1);
    drive_pix(11'd256, 10'd32, 1'b1);
    drive_pix(11'd257, 10'd32, 1'b1);
    drive_pix(11'd258, 10'd32, 1'b1);
    #2;
    check_val("pre_rst_vp", {31'd0, valid_pixel}, 32'd1);
    reset = 1'b0;
    #1;
    check_val("arst_vp", {31'd0, valid_pixel}, 32'd0);
    check_val("arst_rgb", {8'd0, r, g, b}, 32'd0);
    check_val("arst_addr", {14'd0, read_address}, 32'd0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    drive_pix(11'd300, 10'd40, 1'b1);
    #1;
    check_val("post_rst_buf0", {31'd0, read_address[8]}, 32'd0);
    check_val("post_rst_buf1", {31'd0, read_address[17]}, 32'd0);
    scan_row(10'd32, 250, 270);
    drive_pix(11'd256, 10'd32, 1'b1, 1'b1, 1'b1, 24'hFFFF00);
    idle2();
    idle2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
